// File: rtl/crossbar_pkg.sv
// Shared types and constants for the crossbar master port.
package crossbar_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } xbar_mport_state_t;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    // Read data returned to the master when a request is aborted
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_DATA_W = 32;

endpackage

// File: rtl/crossbar_timeout_cnt.sv
// Request-age counter: cleared on load, counts while enabled, flags the cycle
// in which the count reaches TIMEOUT.
module crossbar_timeout_cnt #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the cycle whose increment would make the count equal TIMEOUT
    assign expire_o = en_i & (cnt_q == CNT_LAST);

endmodule

// File: rtl/crossbar_master_port.sv
// Registered master-side port in front of a crossbar master input.
// Optional request timeout is built when CROSSBAR_MASTER_TIMEOUT_EN is defined.
module crossbar_master_port
    import crossbar_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_from_master,
    input  logic [ADDR_W-1:0] addr_from_master,
    input  logic [DATA_W-1:0] wdata_from_master,
    input  logic              cmd_from_master,
    output logic              ack_to_master,
    output logic [DATA_W-1:0] rdata_to_master,
    output logic              err_to_master,
    output logic              req_to_crossbar,
    output logic [ADDR_W-1:0] addr_to_crossbar,
    output logic [DATA_W-1:0] wdata_to_crossbar,
    output logic              cmd_to_crossbar,
    input  logic              ack_from_crossbar,
    input  logic [DATA_W-1:0] rdata_from_crossbar,
    input  logic              connect_approved_from_crossbar
);

    // Handshake: a request is presented on req_to_crossbar with addr/wdata/cmd
    // frozen until a cycle where ack_from_crossbar and the grant are both 1;
    // that cycle completes it. ack_to_master is a one-cycle pulse afterwards.

    xbar_mport_state_t state_q, state_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              cmd_q, cmd_d;
    logic              ack_q, ack_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic done;
    logic timeout_expire;
    logic cnt_clear;
    logic cnt_en;

    assign done      = ack_from_crossbar & connect_approved_from_crossbar;
    assign cnt_clear = (state_q == IDLE) & req_from_master;
    assign cnt_en    = (state_q == REQ) & ~done;

`ifdef CROSSBAR_MASTER_TIMEOUT_EN
    crossbar_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (cnt_clear),
        .en_i     (cnt_en),
        .expire_o (timeout_expire)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^{cnt_clear, cnt_en, TIMEOUT};
    assign timeout_expire     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cmd_d   = cmd_q;
        ack_d   = 1'b0;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_from_master) begin
                    addr_d  = addr_from_master;
                    wdata_d = wdata_from_master;
                    cmd_d   = cmd_from_master;
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                // A real completion takes priority over a same-cycle expiry
                if (done) begin
                    req_d   = 1'b0;
                    rdata_d = (cmd_q == CMD_READ) ? rdata_from_crossbar : '0;
                    err_d   = 1'b0;
                    ack_d   = 1'b1;
                    state_d = RESP;
                end else if (timeout_expire) begin
                    req_d   = 1'b0;
                    rdata_d = DATA_W'(TIMEOUT_RDATA);
                    err_d   = 1'b1;
                    ack_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cmd_q   <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cmd_q   <= cmd_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_to_crossbar   = req_q;
    assign addr_to_crossbar  = addr_q;
    assign wdata_to_crossbar = wdata_q;
    assign cmd_to_crossbar   = cmd_q;
    assign ack_to_master     = ack_q;
    assign rdata_to_master   = rdata_q;
    assign err_to_master     = err_q;

endmodule

// File: tb/tb_crossbar_master_port.sv
// Directed bench for crossbar_master_port: stimulus pushes expected responses,
// a negedge monitor pops and compares them on every ack_to_master pulse.
module tb_crossbar_master_port;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst_n;
    logic              req_from_master;
    logic [ADDR_W-1:0] addr_from_master;
    logic [DATA_W-1:0] wdata_from_master;
    logic              cmd_from_master;
    logic              ack_to_master;
    logic [DATA_W-1:0] rdata_to_master;
    logic              err_to_master;
    logic              req_to_crossbar;
    logic [ADDR_W-1:0] addr_to_crossbar;
    logic [DATA_W-1:0] wdata_to_crossbar;
    logic              cmd_to_crossbar;
    logic              ack_from_crossbar;
    logic [DATA_W-1:0] rdata_from_crossbar;
    logic              connect_approved_from_crossbar;

    logic [DATA_W:0] exp_q[$];
    int              n_tests = 0;
    int              n_fail  = 0;
    int              cyc     = 0;
    logic            prev_ack = 1'b0;

    crossbar_master_port #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (4)
    ) dut (
        .clk                            (clk),
        .rst_n                          (rst_n),
        .req_from_master                (req_from_master),
        .addr_from_master               (addr_from_master),
        .wdata_from_master              (wdata_from_master),
        .cmd_from_master                (cmd_from_master),
        .ack_to_master                  (ack_to_master),
        .rdata_to_master                (rdata_to_master),
        .err_to_master                  (err_to_master),
        .req_to_crossbar                (req_to_crossbar),
        .addr_to_crossbar               (addr_to_crossbar),
        .wdata_to_crossbar              (wdata_to_crossbar),
        .cmd_to_crossbar                (cmd_to_crossbar),
        .ack_from_crossbar              (ack_from_crossbar),
        .rdata_from_crossbar            (rdata_from_crossbar),
        .connect_approved_from_crossbar (connect_approved_from_crossbar)
    );

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [DATA_W:0] e;
        if (rst_n && ack_to_master) begin
            check("ack_pulse_width", {63'b0, prev_ack}, 64'd0);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_ack: got ack with empty queue, required no ack (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                check("rdata_to_master", 64'(rdata_to_master), 64'(e[DATA_W-1:0]));
                check("err_to_master", 64'(err_to_master), 64'(e[DATA_W]));
            end
        end
        prev_ack = ack_to_master;
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic c);
        req_from_master   = 1'b1;
        addr_from_master  = a;
        wdata_from_master = wd;
        cmd_from_master   = c;
        tick();
        req_from_master = 1'b0;
        check("req_rise", 64'(req_to_crossbar), 64'd1);
        check("addr_capture", 64'(addr_to_crossbar), 64'(a));
        check("wdata_capture", 64'(wdata_to_crossbar), 64'(wd));
        check("cmd_capture", 64'(cmd_to_crossbar), 64'(c));
    endtask

    task automatic complete(input logic [31:0] rd, input logic [DATA_W:0] exp);
        ack_from_crossbar              = 1'b1;
        connect_approved_from_crossbar = 1'b1;
        rdata_from_crossbar            = rd;
        exp_q.push_back(exp);
        tick();
        ack_from_crossbar              = 1'b0;
        connect_approved_from_crossbar = 1'b0;
        rdata_from_crossbar            = 32'h0;
        check("req_drop_on_ack", 64'(req_to_crossbar), 64'd0);
        check("ack_high", 64'(ack_to_master), 64'd1);
        tick();
        check("ack_low", 64'(ack_to_master), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"}, 64'(ack_to_master), 64'd0);
        check({tag, "_rdata"}, 64'(rdata_to_master), 64'd0);
        check({tag, "_err"}, 64'(err_to_master), 64'd0);
        check({tag, "_req"}, 64'(req_to_crossbar), 64'd0);
        check({tag, "_addr"}, 64'(addr_to_crossbar), 64'd0);
        check({tag, "_wdata"}, 64'(wdata_to_crossbar), 64'd0);
        check({tag, "_cmd"}, 64'(cmd_to_crossbar), 64'd0);
    endtask

    logic [31:0] b2b_addr [3];
    logic [31:0] b2b_data [3];
    int          last_ack_cyc;

    initial begin
        rst_n                          = 1'b0;
        req_from_master                = 1'b0;
        addr_from_master               = '0;
        wdata_from_master              = '0;
        cmd_from_master                = 1'b0;
        ack_from_crossbar              = 1'b0;
        rdata_from_crossbar            = '0;
        connect_approved_from_crossbar = 1'b0;
        b2b_addr = '{32'h0000_0100, 32'h8000_0200, 32'h0000_0300};
        b2b_data = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};

        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();
        check("idle_no_req", 64'(req_to_crossbar), 64'd0);

        // Read, acked two cycles after the request rises
        issue(32'h0000_0010, 32'h0, 1'b0);
        tick();
        check("read_wait1_req", 64'(req_to_crossbar), 64'd1);
        tick();
        check("read_wait2_req", 64'(req_to_crossbar), 64'd1);
        complete(32'h1234_5678, {1'b0, 32'h1234_5678});

        // Write; master inputs change after capture and must be ignored
        issue(32'h8000_0004, 32'hCAFE_0001, 1'b1);
        addr_from_master  = 32'h1111_1111;
        wdata_from_master = 32'h2222_2222;
        cmd_from_master   = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            check("write_hold_addr", 64'(addr_to_crossbar), 64'h8000_0004);
            check("write_hold_wdata", 64'(wdata_to_crossbar), 64'hCAFE_0001);
            check("write_hold_cmd", 64'(cmd_to_crossbar), 64'd1);
        end
        complete(32'hFFFF_FFFF, {1'b0, 32'h0});

        // Ack without grant for three cycles is ignored
        issue(32'h0000_0020, 32'h0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            ack_from_crossbar              = 1'b1;
            connect_approved_from_crossbar = 1'b0;
            rdata_from_crossbar            = 32'hAAAA_5555;
            tick();
            check("nogrant_req_held", 64'(req_to_crossbar), 64'd1);
            check("nogrant_no_ack", 64'(ack_to_master), 64'd0);
        end
        complete(32'h0BAD_F00D, {1'b0, 32'h0BAD_F00D});

        // Back-to-back with req held high: ack every 3 cycles, fresh address
        req_from_master = 1'b1;
        cmd_from_master = 1'b0;
        last_ack_cyc    = 0;
        for (int i = 0; i < 3; i++) begin
            addr_from_master = b2b_addr[i];
            tick();
            check("b2b_addr", 64'(addr_to_crossbar), 64'(b2b_addr[i]));
            check("b2b_req", 64'(req_to_crossbar), 64'd1);
            addr_from_master               = 32'hFFFF_0000 | 32'(i);
            ack_from_crossbar              = 1'b1;
            connect_approved_from_crossbar = 1'b1;
            rdata_from_crossbar            = b2b_data[i];
            exp_q.push_back({1'b0, b2b_data[i]});
            tick();
            ack_from_crossbar              = 1'b0;
            connect_approved_from_crossbar = 1'b0;
            check("b2b_ack", 64'(ack_to_master), 64'd1);
            check("b2b_resp_req_low", 64'(req_to_crossbar), 64'd0);
            if (i > 0) check("b2b_interval", 64'(cyc - last_ack_cyc), 64'd3);
            last_ack_cyc = cyc;
            tick();
            check("b2b_ack_low", 64'(ack_to_master), 64'd0);
            check("b2b_idle_req_low", 64'(req_to_crossbar), 64'd0);
        end
        req_from_master = 1'b0;
        tick();

`ifdef CROSSBAR_MASTER_TIMEOUT_EN
        // Timeout after 4 REQ cycles with no ack
        issue(32'h0000_0040, 32'h0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("to_req_held", 64'(req_to_crossbar), 64'd1);
        end
        exp_q.push_back({1'b1, 32'hDEAD_BEEF});
        tick();
        check("to_req_drop", 64'(req_to_crossbar), 64'd0);
        check("to_ack", 64'(ack_to_master), 64'd1);
        tick();

        // Ack arriving in the expiry cycle wins
        issue(32'h0000_0044, 32'h0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
        end
        check("to_race_req_held", 64'(req_to_crossbar), 64'd1);
        complete(32'h5A5A_5A5A, {1'b0, 32'h5A5A_5A5A});
`endif

        // Asynchronous reset in the middle of REQ
        issue(32'h0000_0050, 32'h0000_0077, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        tick();
        rst_n = 1'b1;
        tick();
        check("post_reset_req", 64'(req_to_crossbar), 64'd0);
        issue(32'h0000_0060, 32'h0, 1'b0);
        complete(32'h0F0F_F0F0, {1'b0, 32'h0F0F_F0F0});

        tick();
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/crossbar_master_port.md
# crossbar_master_port

Registered master-side port placed between one bus master and a master input of `crossbar_2m2s`. It captures a master request into holding registers and drives it to the crossbar, stable, until the crossbar returns ack. It then registers ack and read data back to the master. An optional timeout aborts requests that the crossbar never completes.

## Interface
Parameters:
- `ADDR_W`, 32, address width; bit `ADDR_W-1` is the crossbar's slave-select bit.
- `DATA_W`, 32, wdata/rdata width.
- `TIMEOUT`, 255, cycles in REQ without ack before abort; legal range 1..65535; used only with the macro.

Ports (one clock; reset is asynchronous and active-low):
- `clk`, in, 1, rising-edge clock.
- `rst_n`, in, 1, asynchronous active-low reset.
- `req_from_master`, in, 1, request valid.
- `addr_from_master`, in, ADDR_W, request address.
- `wdata_from_master`, in, DATA_W, write data.
- `cmd_from_master`, in, 1, command: 1 = write, 0 = read.
- `ack_to_master`, out, 1, one-cycle completion pulse.
- `rdata_to_master`, out, DATA_W, read data; valid while `ack_to_master` is 1.
- `err_to_master`, out, 1, timeout flag; valid while `ack_to_master` is 1.
- `req_to_crossbar`, out, 1, registered request to the crossbar.
- `addr_to_crossbar`, out, ADDR_W, held address.
- `wdata_to_crossbar`, out, DATA_W, held write data.
- `cmd_to_crossbar`, out, 1, held command.
- `ack_from_crossbar`, in, 1, slave ack routed through the crossbar.
- `rdata_from_crossbar`, in, DATA_W, slave read data routed through the crossbar.
- `connect_approved_from_crossbar`, in, 1, arbitration grant for this master.

## Operation
- FSM states: IDLE, REQ, RESP. Reset enters IDLE.
- Reset value of every output: 0. Holding registers and the counter also reset to 0.
- IDLE:
  - If `req_from_master` is 1: capture addr/wdata/cmd, set `req_to_crossbar`, go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - `req_to_crossbar` stays 1; addr/wdata/cmd stay frozen. Master inputs are ignored.
  - Completion requires `ack_from_crossbar & connect_approved_from_crossbar`. An ack without grant is ignored.
  - On completion:
    - Clear `req_to_crossbar`.
    - Latch rdata: `rdata_from_crossbar` if cmd = read, 0 if cmd = write.
    - Set `err_to_master` to 0. Go to RESP.
  - If the grant drops while waiting (lost arbitration), keep the request asserted and keep waiting.
- RESP:
  - `ack_to_master` is 1 for exactly one cycle, with rdata and err.
  - Next edge: go to IDLE unconditionally and clear `ack_to_master`.
- A new request held by the master during RESP is not captured until the IDLE edge that follows.
- `rdata_to_master` holds its last value after ack; it is valid only while ack is 1.

## Timing
- Request path:
  - Master req sampled at edge N.
  - `req_to_crossbar` is high from cycle N+1.
- Response path:
  - Crossbar ack+grant sampled at edge M.
  - `ack_to_master` is high in cycle M+1 only.
  - `req_to_crossbar` is low from cycle M+1.
- Minimum transaction: 3 cycles (IDLE→REQ→RESP→IDLE) with a same-cycle ack in the first REQ cycle.
- Peak rate: one transaction per 3 cycles.
- Simultaneous ack+grant and timeout expiry in the same cycle: the ack wins, and `err_to_master` is 0.
- Reset asserted mid-transaction:
  - All outputs are 0 immediately (asynchronous).
  - Any in-flight crossbar request is dropped.
  - The crossbar's arbitration history is its own concern.

## Configuration
- Macro: `CROSSBAR_MASTER_TIMEOUT_EN`.
- Defined:
  - Counter increments every REQ cycle without ack+grant; it clears on entering REQ.
  - When the counter reaches `TIMEOUT`: clear `req_to_crossbar`, set rdata = `TIMEOUT_RDATA` (32'hDEAD_BEEF truncated to DATA_W), set `err_to_master` = 1, go to RESP.
- Undefined:
  - No counter is built and `TIMEOUT` is unused.
  - `err_to_master` is tied to 0.
  - REQ waits indefinitely.

## Structure
- Package `crossbar_pkg` holds:
  - the state enum `xbar_mport_state_t` (IDLE, REQ, RESP);
  - `CMD_READ` = 1'b0 and `CMD_WRITE` = 1'b1;
  - `TIMEOUT_RDATA`;
  - the default `ADDR_W`/`DATA_W` constants.
- Sub-module `crossbar_timeout_cnt`:
  - Load-clear / enable / expire counter, width `$clog2(TIMEOUT+1)`.
  - Instantiated only under the macro.

## Test plan
- Read to addr 32'h0000_0010:
  - Crossbar gives grant+ack with rdata 32'h1234_5678 two cycles after `req_to_crossbar` rises.
  - Required: `ack_to_master` is a 1-cycle pulse, rdata = 32'h1234_5678, err = 0, `req_to_crossbar` low the same cycle.
- Write to addr 32'h8000_0004 with wdata 32'hCAFE_0001:
  - Master changes addr/wdata in the cycle after capture.
  - Required: crossbar outputs stay 32'h8000_0004 / 32'hCAFE_0001 until ack; `rdata_to_master` = 0.
- Ack asserted for 3 cycles with grant = 0, then grant+ack:
  - Required: no `ack_to_master` until the grant cycle + 1; request held throughout.
- Master keeps req high continuously for 3 transactions, each acked immediately:
  - Required: `ack_to_master` pulses exactly every 3 cycles; each capture takes fresh addr.
- With the macro and `TIMEOUT` = 4, no ack:
  - Required: `req_to_crossbar` drops after 4 REQ cycles; ack = 1, err = 1, rdata = 32'hDEAD_BEEF.
  - Variant with ack in the expiry cycle: err = 0.
- `rst_n` pulled low during REQ:
  - Required: all outputs 0 asynchronously; after release, FSM in IDLE and the next request behaves normally.
